// File: rtl/ctrl_pipeline_if.sv
// ctrl_pipeline_if
//   Bundles the instruction-decode handshake, the per-stage control outputs
//   and the syscall request/acknowledge pair of the pipelined main control.
//
//   master : the environment side (drives ID fields, stall/flush, syscall_ack)
//   slave  : the ctrl_pipeline side (drives id_ready, stage controls,
//            illegal and syscall_req)
//
//   ALUOP_W : width of the ALU op code carried into EX (>= 3)
interface ctrl_pipeline_if #(
    parameter int ALUOP_W = 3
);
    // ID stage
    logic [5:0]         opcode;
    logic [5:0]         func_code;
    logic               id_valid;
    logic               stall;
    logic               flush;
    logic               id_ready;

    // EX stage
    logic               ex_valid;
    logic               ex_reg_dst;
    logic               ex_alu_src;
    logic               ex_branch;
    logic               ex_jump;
    logic               ex_jal;
    logic               ex_jr;
    logic [ALUOP_W-1:0] ex_alu_op;

    // MEM stage
    logic               mem_valid;
    logic               mem_read;
    logic               mem_write;

    // WB stage
    logic               wb_valid;
    logic               wb_reg_write;
    logic               wb_mem_to_reg;

    // Status / syscall handshake
    logic               illegal;
    logic               syscall_req;
    logic               syscall_ack;

    modport master (
        output opcode, func_code, id_valid, stall, flush, syscall_ack,
        input  id_ready,
        input  ex_valid, ex_reg_dst, ex_alu_src, ex_branch, ex_jump, ex_jal, ex_jr, ex_alu_op,
        input  mem_valid, mem_read, mem_write,
        input  wb_valid, wb_reg_write, wb_mem_to_reg,
        input  illegal, syscall_req
    );

    modport slave (
        input  opcode, func_code, id_valid, stall, flush, syscall_ack,
        output id_ready,
        output ex_valid, ex_reg_dst, ex_alu_src, ex_branch, ex_jump, ex_jal, ex_jr, ex_alu_op,
        output mem_valid, mem_read, mem_write,
        output wb_valid, wb_reg_write, wb_mem_to_reg,
        output illegal, syscall_req
    );
endinterface

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
//   Pipelined main control for the MIPS core. Decodes opcode/func_code in ID
//   and carries the control bits through EX, MEM and WB registers with a
//   valid bit per stage. Bubbles carry all-zero controls, so every control
//   output is 0 whenever its stage is invalid. A small RUN/DRAIN/CALL state
//   machine empties the pipeline before a SYSCALL is handed to the
//   environment through syscall_req/syscall_ack; a syscall never enters EX.
//
//   Ports:
//     clk   : clock, all state on the rising edge
//     rst_b : asynchronous active-low reset
//     bus   : ctrl_pipeline_if slave (ID handshake, stage controls, syscall)
//
//   Parameters:
//     ALUOP_W : ALU op width (>= 3), codes zero-extended
//     EXT_EN  : 1 also decodes ANDI (0x0c) and SLTI (0x0a)
module ctrl_pipeline #(
    parameter int ALUOP_W = 3,
    parameter bit EXT_EN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_b,
    ctrl_pipeline_if.slave   bus
);

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03,
                           OP_BEQ     = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08,
                           OP_ADDIU   = 6'h09, OP_SLTI = 6'h0a, OP_ANDI  = 6'h0c,
                           OP_ORI     = 6'h0d, OP_LW   = 6'h23, OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR  = 6'h08, FN_SYSCALL = 6'h0c, FN_ADD = 6'h20,
                           FN_SUB = 6'h22, FN_AND     = 6'h24, FN_OR  = 6'h25,
                           FN_SLT = 6'h2a;

    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(7);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CALL} state_e;

    // Everything EX needs, plus the bits it forwards to MEM and WB.
    typedef struct packed {
        logic               reg_dst;
        logic               alu_src;
        logic               branch;
        logic               jump;
        logic               jal;
        logic               jr;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
    } ex_ctl_t;

    typedef struct packed {
        logic valid;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } mem_stage_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
    } wb_stage_t;

    // Decode results
    ex_ctl_t    dec;
    logic       legal;
    logic       is_syscall;

    // Pipeline state
    state_e     state_q, state_d;
    logic       ex_valid_q, ex_valid_d;
    ex_ctl_t    ex_ctl_q, ex_ctl_d;
    mem_stage_t mem_q, mem_d;
    wb_stage_t  wb_q, wb_d;
    logic       illegal_q, illegal_d;
    logic       syscall_req_q, syscall_req_d;

    logic       id_ready;
    logic       take;
    logic       pipe_empty;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default before the
    // case statements; a path that skips an assignment would infer a latch.
    always_comb begin
        dec        = '0;
        legal      = 1'b1;
        is_syscall = 1'b0;
        case (bus.opcode)
            OP_SPECIAL: begin
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                case (bus.func_code)
                    FN_ADD: dec.alu_op = ALU_ADD;
                    FN_SUB: dec.alu_op = ALU_SUB;
                    FN_AND: dec.alu_op = ALU_AND;
                    FN_OR:  dec.alu_op = ALU_OR;
                    FN_SLT: dec.alu_op = ALU_SLT;
                    FN_JR: begin
                        dec.reg_dst   = 1'b0;
                        dec.reg_write = 1'b0;
                        dec.jump      = 1'b1;
                        dec.jr        = 1'b1;
                    end
                    FN_SYSCALL: begin
                        dec.reg_write = 1'b0;
                        is_syscall    = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_J:   dec.jump = 1'b1;
            OP_JAL: begin
                dec.jump      = 1'b1;
                dec.jal       = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
            end
            OP_ADDI, OP_ADDIU: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            OP_ORI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_OR;
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            OP_ANDI: begin
                if (EXT_EN) begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.alu_op    = ALU_AND;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_SLTI: begin
                if (EXT_EN) begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.alu_op    = ALU_SLT;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake, stage advance and syscall state machine
    // ------------------------------------------------------------------
    always_comb begin
        pipe_empty = !(ex_valid_q || mem_q.valid || wb_q.valid);

        id_ready = ((state_q == ST_RUN) && !bus.stall && !is_syscall) ||
                   ((state_q == ST_CALL) && bus.syscall_ack);

        // Consumption in CALL is the syscall itself, which never enters EX,
        // so only RUN can feed the pipeline. flush squashes the ID slot.
        take = (state_q == ST_RUN) && id_ready && bus.id_valid && !bus.flush;

        ex_valid_d = take && legal;
        ex_ctl_d   = (take && legal) ? dec : '0;
        illegal_d  = take && !legal;

        mem_d.valid      = ex_valid_q;
        mem_d.mem_read   = ex_ctl_q.mem_read;
        mem_d.mem_write  = ex_ctl_q.mem_write;
        mem_d.reg_write  = ex_ctl_q.reg_write;
        mem_d.mem_to_reg = ex_ctl_q.mem_to_reg;

        wb_d.valid      = mem_q.valid;
        wb_d.reg_write  = mem_q.reg_write;
        wb_d.mem_to_reg = mem_q.mem_to_reg;

        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.id_valid && is_syscall && !bus.stall && !bus.flush)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.flush)
                    state_d = ST_RUN;
                else if (pipe_empty)
                    state_d = ST_CALL;
            end
            ST_CALL: begin
                if (bus.syscall_ack)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        // Registered request: high exactly while the FSM sits in CALL.
        syscall_req_d = (state_d == ST_CALL);
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= ST_RUN;
            ex_valid_q    <= 1'b0;
            ex_ctl_q      <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            illegal_q     <= 1'b0;
            syscall_req_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ex_valid_q    <= ex_valid_d;
            ex_ctl_q      <= ex_ctl_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            illegal_q     <= illegal_d;
            syscall_req_q <= syscall_req_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.id_ready      = id_ready;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_reg_dst    = ex_ctl_q.reg_dst;
    assign bus.ex_alu_src    = ex_ctl_q.alu_src;
    assign bus.ex_branch     = ex_ctl_q.branch;
    assign bus.ex_jump       = ex_ctl_q.jump;
    assign bus.ex_jal        = ex_ctl_q.jal;
    assign bus.ex_jr         = ex_ctl_q.jr;
    assign bus.ex_alu_op     = ex_ctl_q.alu_op;
    assign bus.mem_valid     = mem_q.valid;
    assign bus.mem_read      = mem_q.mem_read;
    assign bus.mem_write     = mem_q.mem_write;
    assign bus.wb_valid      = wb_q.valid;
    assign bus.wb_reg_write  = wb_q.reg_write;
    assign bus.wb_mem_to_reg = wb_q.mem_to_reg;
    assign bus.illegal       = illegal_q;
    assign bus.syscall_req   = syscall_req_q;

endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Pipelined main-control block for the MIPS core. It decodes opcode/function code in ID and carries the resulting control bits through per-stage registers into EX, MEM and WB, with valid bits, stall and flush support. It also adds a syscall drain state machine: the pipeline is emptied before a syscall is issued to the environment through a request/acknowledge handshake. It replaces purely combinational control between the instruction register and the datapath.

## Interface
- `ALUOP_W`, default 3: ALU op width, ≥3. Codes are zero-extended.
- `EXT_EN`, default 0: when 1, also decode ANDI (0x0c) and SLTI (0x0a).
- `clk` in 1: clock, all state on rising edge.
- `rst_b` in 1: reset, asynchronous, active-low.
- `opcode` in 6: instruction [31:26] in ID.
- `func_code` in 6: instruction [5:0] in ID.
- `id_valid` in 1: ID holds an instruction.
- `stall` in 1: hold ID and inject a bubble into EX.
- `flush` in 1: squash the ID instruction.
- `syscall_ack` in 1: environment has completed the syscall.
- `id_ready` out 1: ID instruction consumed this cycle (combinational).
- `ex_valid`, `ex_reg_dst`, `ex_alu_src`, `ex_branch`, `ex_jump`, `ex_jal`, `ex_jr` out 1 each: EX stage controls.
- `ex_alu_op` out `ALUOP_W`: EX stage ALU op.
- `mem_valid`, `mem_read`, `mem_write` out 1 each: MEM stage controls.
- `wb_valid`, `wb_reg_write`, `wb_mem_to_reg` out 1 each: WB stage controls.
- `illegal` out 1: registered one-cycle pulse for an accepted undecodable instruction.
- `syscall_req` out 1: syscall request, registered.

## Operation

**Decode**
- Opcodes: SPECIAL 0x00, J 0x02, JAL 0x03, BEQ 0x04, BNE 0x05, ADDI 0x08, ADDIU 0x09, ORI 0x0d, LW 0x23, SW 0x2b.
- SPECIAL function codes: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2a, JR 0x08, SYSCALL 0x0c.
- ALU op codes: AND=0, OR=1, add=2, sub=6, slt=7.
  - add: ADD, ADDI, ADDIU, LW, SW.
  - sub: SUB, BEQ, BNE.
  - OR: OR, ORI.
  - AND: AND, ANDI.
  - slt: SLT, SLTI.
  - Anything else decodes to 0.
- `reg_dst`: SPECIAL except JR.
- `alu_src`: ADDI, ADDIU, ORI, LW, SW, ANDI, SLTI.
- `reg_write`: SPECIAL except JR/SYSCALL; also ADDI, ADDIU, ORI, LW, ANDI, SLTI, JAL.
- `jump`: J, JAL, JR. `jal`: JAL only. `jr`: SPECIAL/0x08 only.
- `branch`: BEQ, BNE. `mem_read` and `mem_to_reg`: LW. `mem_write`: SW.
- Undecodable instruction (unknown opcode or function code, or ANDI/SLTI when `EXT_EN`=0):
  - enters the pipeline as a bubble (valid=0, all controls 0);
  - `illegal` pulses the cycle after acceptance.

**Pipeline advance (every cycle, never stalls downstream)**
- MEM ← EX; WB ← MEM.
- EX ← decoded ID when the instruction is accepted (`id_ready` && `id_valid` && !`flush` && legal); otherwise EX ← bubble.
- Every control output is 0 whenever its stage's valid bit is 0.

**Syscall FSM**
- States: RUN, DRAIN, CALL.
- `id_ready` = (RUN && !`stall` && !is_syscall) || (CALL && `syscall_ack`).
- RUN → DRAIN: `id_valid` && is_syscall && !`stall` && !`flush`.
- DRAIN → CALL: `ex_valid` | `mem_valid` | `wb_valid` == 0. Exit to RUN if `flush`=1.
- CALL: `syscall_req`=1. `syscall_ack` → RUN, syscall consumed, no pipeline entry. `flush` is ignored in CALL.
- A syscall never enters EX.

**Priority**
- `flush` beats `stall`. `flush` with `stall` produces a bubble and consumes nothing.

## Timing
- Reset (async assert, synchronous-safe release):
  - all stage valid bits and control outputs, `illegal` and `syscall_req` are 0;
  - state is RUN;
  - `id_ready` then follows its equation.
- Latency: an instruction accepted at edge N appears at EX after N, MEM after N+1, WB after N+2.
- `stall` held for k cycles inserts k bubbles; the ID instruction is accepted on the first cycle with `stall`=0.
- Syscall, empty pipeline: `syscall_req` is high 2 edges after presentation.
- Syscall, full pipeline: `syscall_req` is high 4 edges after presentation.
- `syscall_req` falls on the edge after `syscall_ack`. An ack outside CALL is ignored.
- `rst_b` low in DRAIN or CALL:
  - immediate return to RUN with `syscall_req`=0;
  - the syscall is not consumed.

## Test plan
- ADD (op 0, func 0x20) accepted at edge 1:
  - EX at edge 1: `ex_reg_dst`=1, `ex_alu_op`=2.
  - WB at edge 3: `wb_reg_write`=1, `wb_mem_to_reg`=0.
  - All controls are 0 at edge 4 with `id_valid`=0.
- LW then SW back-to-back:
  - `mem_read`=1 at edge 2, then `mem_write`=1 at edge 3.
  - `ex_alu_src`=1 both cycles.
  - `wb_mem_to_reg`=1 at edge 3.
- BEQ held by `stall` for 2 cycles:
  - `id_ready`=0 for 2 cycles, 2 bubbles reach EX.
  - BEQ then appears with `ex_branch`=1 and `ex_alu_op`=6.
- `flush`+`stall` with JAL in ID → EX bubble, `id_ready`=0.
- SYSCALL (func 0x0c) behind ADD, ORI and LW:
  - `syscall_req` rises at edge 4 and stays high until `syscall_ack`.
  - `id_ready`=1 in the ack cycle.
  - `syscall_req`=0 on the next edge.
- ANDI with `EXT_EN`=0 → `illegal` pulse, EX bubble.
- ANDI with `EXT_EN`=1 → `ex_alu_op`=0, `ex_alu_src`=1.
- `rst_b` pulsed low during CALL → `syscall_req` and all valids are 0 asynchronously, and state is RUN.
